// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, LSD first, one digit per clock.
// Ports: clk, rst, start, sub, a, b in; busy, done, s, neg, ovf, invalid out.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  neg,
  output logic                  ovf,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          sub_r;
  logic          cy;

  logic [3:0]    a_d;
  logic [3:0]    b_d;
  logic [3:0]    s_d;
  logic [3:0]    x;
  logic [3:0]    y;
  logic [4:0]    t;
  logic          co;
  logic [3:0]    d;
  logic          bad;

  assign busy = (state != IDLE);

  // One shared digit adder; FIX reuses it with x = 9 - s[i], y = 0
  // to form the ten's complement of the stored result.
  always_comb begin
    a_d = a_r[4*idx +: 4];
    b_d = b_r[4*idx +: 4];
    s_d = s[4*idx +: 4];
    if (state == FIX) begin
      x = 4'd9 - s_d;
      y = 4'd0;
    end else begin
      x = a_d;
      y = sub_r ? (4'd9 - b_d) : b_d;
    end
    t  = {1'b0, x} + {1'b0, y} + {4'd0, cy};
    co = (t > 5'd9);
    d  = co ? 4'(t + 5'd6) : t[3:0];
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      cy      <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            s     <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
            idx   <= '0;
            // subtraction is a + (9's complement of b) + 1
            cy    <= sub;
            if (bad) begin
              invalid <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              invalid <= 1'b0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          s[4*idx +: 4] <= d;
          cy            <= co;
          if (idx == LAST) begin
            idx <= '0;
            if (!sub_r) begin
              ovf   <= co;
              done  <= 1'b1;
              state <= DONE;
            end else if (co) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // no end-around carry: a < b, result is complement
              neg   <= 1'b1;
              cy    <= 1'b1;
              state <= FIX;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIX: begin
          s[4*idx +: 4] <= d;
          cy            <= co;
          if (idx == LAST) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
